// File: rtl/tape_ear_conditioner.sv
// Tape/EAR front end: turns the ADC sample stream and the raw EAR pin into one clean EAR bit,
// with ADC activity detection, source selection and edge-to-edge period measurement.
module tape_ear_conditioner #(
  parameter int unsigned      ADC_W       = 12,
  parameter logic [ADC_W-1:0] TH_HI       = 12'd2458,
  parameter logic [ADC_W-1:0] TH_LO       = 12'd1638,
  parameter int unsigned      GLITCH_CYC  = 8,
  parameter int unsigned      ACT_EDGES   = 4,
  parameter int unsigned      ACT_TIMEOUT = 1000000,
  parameter int unsigned      PER_W       = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             ear_pin,
  input  logic [1:0]       src_sel,
  output logic             ear,
  output logic             adc_active,
  output logic             edge_stb,
  output logic [PER_W-1:0] period
);

  localparam int unsigned GW = $clog2(GLITCH_CYC + 1);
  localparam int unsigned TW = $clog2(ACT_TIMEOUT + 1);
  localparam int unsigned EW = $clog2(ACT_EDGES + 1);
  localparam logic [GW-1:0]    GLITCH_LAST = GW'(GLITCH_CYC - 1);
  localparam logic [TW-1:0]    GAP_MAX     = TW'(ACT_TIMEOUT);
  localparam logic [EW-1:0]    EDGE_LAST   = EW'(ACT_EDGES - 1);
  localparam logic [PER_W-1:0] PER_MAX     = '1;

  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE} actState_e;

  logic             adcLvl_q, adcLvl_d, adcEdge;
  logic             sync1_q, sync2_q, pinLvl_q;
  logic [GW-1:0]    glitchCnt_q;
  actState_e        state_q;
  logic [EW-1:0]    edgeCnt_q;
  logic [TW-1:0]    gap_q;
  logic             adcActive_q;
  logic             selLvl, earEdge;
  logic             ear_q, edgeStb_q;
  logic [PER_W-1:0] period_q, perCnt_q;

  // Levels strictly between the thresholds keep the previous decision.
  always_comb begin
    adcLvl_d = adcLvl_q;
    if (adc_valid) begin
      if (adc_data >= TH_HI)
        adcLvl_d = 1'b1;
      else if (adc_data <= TH_LO)
        adcLvl_d = 1'b0;
    end
  end

  assign adcEdge = adcLvl_d ^ adcLvl_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      adcLvl_q <= 1'b0;
    else
      adcLvl_q <= adcLvl_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pinLvl_q    <= 1'b0;
      glitchCnt_q <= '0;
    end else begin
      sync1_q <= ear_pin;
      sync2_q <= sync1_q;
      if (sync2_q == pinLvl_q) begin
        glitchCnt_q <= '0;
      end else if (glitchCnt_q == GLITCH_LAST) begin
        pinLvl_q    <= ~pinLvl_q;
        glitchCnt_q <= '0;
      end else begin
        glitchCnt_q <= glitchCnt_q + 1'b1;
      end
    end
  end

  // An ADC edge in the same cycle as the timeout takes priority, so activity is never dropped then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      edgeCnt_q   <= '0;
      gap_q       <= '0;
      adcActive_q <= 1'b0;
    end else begin
      if (adcEdge)
        gap_q <= '0;
      else if (gap_q != GAP_MAX)
        gap_q <= gap_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (adcEdge) begin
            state_q   <= ARMING;
            edgeCnt_q <= EW'(1);
          end
        end
        ARMING: begin
          if (adcEdge) begin
            if (edgeCnt_q == EDGE_LAST) begin
              state_q     <= ACTIVE;
              adcActive_q <= 1'b1;
            end
            edgeCnt_q <= edgeCnt_q + 1'b1;
          end else if (gap_q == GAP_MAX) begin
            state_q   <= IDLE;
            edgeCnt_q <= '0;
          end
        end
        ACTIVE: begin
          if (!adcEdge && gap_q == GAP_MAX) begin
            state_q     <= IDLE;
            edgeCnt_q   <= '0;
            adcActive_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          edgeCnt_q   <= '0;
          adcActive_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    selLvl = 1'b0;
    case (src_sel)
      2'd0:    selLvl = adcActive_q ? adcLvl_q : pinLvl_q;
      2'd1:    selLvl = adcLvl_q;
      2'd2:    selLvl = pinLvl_q;
      default: selLvl = 1'b0;
    endcase
  end

  assign earEdge = selLvl ^ ear_q;

  // The period counter restarts at 1 on an edge so the reported value is the full edge spacing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ear_q     <= 1'b0;
      edgeStb_q <= 1'b0;
      period_q  <= '0;
      perCnt_q  <= '0;
    end else begin
      ear_q     <= selLvl;
      edgeStb_q <= earEdge;
      if (earEdge) begin
        period_q <= perCnt_q;
        perCnt_q <= PER_W'(1);
      end else if (perCnt_q != PER_MAX) begin
        perCnt_q <= perCnt_q + 1'b1;
      end
    end
  end

  assign ear        = ear_q;
  assign adc_active = adcActive_q;
  assign edge_stb   = edgeStb_q;
  assign period     = period_q;

endmodule
